// File: rtl/rv64g_l1_bank_arbiter_pkg.sv
// Shared encodings for the L1 data-array bank arbiter.
package rv64g_l1_pkg;

  localparam int WORD_W = 64;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_SC   = 2'd1;
  localparam logic [1:0] OWN_VEC  = 2'd2;
  localparam logic [1:0] OWN_REF  = 2'd3;

  function automatic int age_width(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/rv64g_l1_bank_arbiter_if.sv
// Requester, response and bank-array bus of the L1 bank arbiter.
interface rv64g_l1_bank_arbiter_if #(
  parameter int NUM_BANKS = 8,
  parameter int INDEX_W   = 5
);
  logic                      refill_req_i;
  logic [INDEX_W-1:0]        refill_index_i;
  logic [2:0]                refill_way_i;
  logic [NUM_BANKS*64-1:0]   refill_data_i;
  logic                      refill_gnt_o;

  logic                      sc_req_i;
  logic                      sc_we_i;
  logic [INDEX_W-1:0]        sc_index_i;
  logic [2:0]                sc_word_i;
  logic [2:0]                sc_way_i;
  logic [7:0]                sc_be_i;
  logic [63:0]               sc_wdata_i;
  logic                      sc_gnt_o;
  logic                      sc_rvalid_o;
  logic [63:0]               sc_rdata_o;

  logic [NUM_BANKS-1:0]         vec_req_i;
  logic [NUM_BANKS-1:0]         vec_we_i;
  logic [NUM_BANKS*INDEX_W-1:0] vec_index_i;
  logic [NUM_BANKS*3-1:0]       vec_word_i;
  logic [NUM_BANKS*3-1:0]       vec_way_i;
  logic [NUM_BANKS*8-1:0]       vec_be_i;
  logic [NUM_BANKS*64-1:0]      vec_wdata_i;
  logic [NUM_BANKS*3-1:0]       vec_src_lane_i;
  logic [NUM_BANKS-1:0]         vec_gnt_o;
  logic [NUM_BANKS-1:0]         vec_rvalid_o;
  logic [NUM_BANKS*64-1:0]      vec_rdata_o;
  logic [NUM_BANKS*3-1:0]       vec_rlane_o;

  logic [NUM_BANKS-1:0]         arr_req_o;
  logic [NUM_BANKS-1:0]         arr_we_o;
  logic [NUM_BANKS*INDEX_W-1:0] arr_index_o;
  logic [NUM_BANKS*3-1:0]       arr_word_o;
  logic [NUM_BANKS*3-1:0]       arr_way_o;
  logic [NUM_BANKS*8-1:0]       arr_be_o;
  logic [NUM_BANKS*64-1:0]      arr_wdata_o;
  logic [NUM_BANKS*64-1:0]      arr_rdata_i;

  logic [31:0]               perf_conflict_o;
  logic [31:0]               perf_refstall_o;

  modport slave (
    input  refill_req_i, refill_index_i, refill_way_i, refill_data_i,
    input  sc_req_i, sc_we_i, sc_index_i, sc_word_i, sc_way_i, sc_be_i, sc_wdata_i,
    input  vec_req_i, vec_we_i, vec_index_i, vec_word_i, vec_way_i, vec_be_i,
    input  vec_wdata_i, vec_src_lane_i, arr_rdata_i,
    output refill_gnt_o, sc_gnt_o, sc_rvalid_o, sc_rdata_o,
    output vec_gnt_o, vec_rvalid_o, vec_rdata_o, vec_rlane_o,
    output arr_req_o, arr_we_o, arr_index_o, arr_word_o, arr_way_o, arr_be_o, arr_wdata_o,
    output perf_conflict_o, perf_refstall_o
  );

  modport master (
    output refill_req_i, refill_index_i, refill_way_i, refill_data_i,
    output sc_req_i, sc_we_i, sc_index_i, sc_word_i, sc_way_i, sc_be_i, sc_wdata_i,
    output vec_req_i, vec_we_i, vec_index_i, vec_word_i, vec_way_i, vec_be_i,
    output vec_wdata_i, vec_src_lane_i, arr_rdata_i,
    input  refill_gnt_o, sc_gnt_o, sc_rvalid_o, sc_rdata_o,
    input  vec_gnt_o, vec_rvalid_o, vec_rdata_o, vec_rlane_o,
    input  arr_req_o, arr_we_o, arr_index_o, arr_word_o, arr_way_o, arr_be_o, arr_wdata_o,
    input  perf_conflict_o, perf_refstall_o
  );
endinterface

// File: rtl/rv64g_l1_bank_arbiter_slice.sv
// One data bank: refill > scalar > vector priority with vector starvation
// override, age counter, owner/lane pipe and read-response select.
module rv64g_l1_bank_arb_slice
  import rv64g_l1_pkg::*;
#(
  parameter int         INDEX_W      = 5,
  parameter int         RD_LAT       = 1,
  parameter int         STARVE_LIMIT = 3,
  parameter logic [2:0] BANK_ID      = 3'd0
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               refill_req,
  input  logic [INDEX_W-1:0] refill_index,
  input  logic [2:0]         refill_way,
  input  logic [63:0]        refill_wdata,
  input  logic               sc_req,
  input  logic               sc_we,
  input  logic [INDEX_W-1:0] sc_index,
  input  logic [2:0]         sc_word,
  input  logic [2:0]         sc_way,
  input  logic [7:0]         sc_be,
  input  logic [63:0]        sc_wdata,
  input  logic               vec_req,
  input  logic               vec_we,
  input  logic [INDEX_W-1:0] vec_index,
  input  logic [2:0]         vec_word,
  input  logic [2:0]         vec_way,
  input  logic [7:0]         vec_be,
  input  logic [63:0]        vec_wdata,
  input  logic [2:0]         vec_lane,
  input  logic [63:0]        arr_rdata,
  output logic               sc_gnt,
  output logic               vec_gnt,
  output logic               arr_req,
  output logic               arr_we,
  output logic [INDEX_W-1:0] arr_index,
  output logic [2:0]         arr_word,
  output logic [2:0]         arr_way,
  output logic [7:0]         arr_be,
  output logic [63:0]        arr_wdata,
  output logic               sc_rvalid,
  output logic [63:0]        sc_rdata,
  output logic               vec_rvalid,
  output logic [63:0]        vec_rdata,
  output logic [2:0]         vec_rlane
);
  localparam int                AGE_W   = age_width(STARVE_LIMIT);
  localparam logic [AGE_W-1:0]  AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0] age;
  logic             sel_ref, sel_sc, sel_vec;
  logic [1:0]       own_in;
  logic [1:0]       own_p  [RD_LAT];
  logic [2:0]       lane_p [RD_LAT];
  logic [1:0]       own_out;

  always_comb begin
    sel_ref = 1'b0;
    sel_sc  = 1'b0;
    sel_vec = 1'b0;
    if (!rst_i) begin
      if (refill_req)              sel_ref = 1'b1;
      else if (sc_req && vec_req)  begin
        if (age == AGE_MAX) sel_vec = 1'b1;
        else                sel_sc  = 1'b1;
      end
      else if (sc_req)             sel_sc  = 1'b1;
      else if (vec_req)            sel_vec = 1'b1;
    end
  end

  always_comb begin
    arr_req   = 1'b0;
    arr_we    = 1'b0;
    arr_index = '0;
    arr_word  = '0;
    arr_way   = '0;
    arr_be    = '0;
    arr_wdata = '0;
    own_in    = OWN_NONE;
    if (sel_ref) begin
      arr_req   = 1'b1;
      arr_we    = 1'b1;
      arr_index = refill_index;
      arr_word  = BANK_ID;
      arr_way   = refill_way;
      arr_be    = 8'hFF;
      arr_wdata = refill_wdata;
    end else if (sel_sc) begin
      arr_req   = 1'b1;
      arr_we    = sc_we;
      arr_index = sc_index;
      arr_word  = sc_word;
      arr_way   = sc_way;
      arr_be    = sc_be;
      arr_wdata = sc_wdata;
      own_in    = sc_we ? OWN_NONE : OWN_SC;
    end else if (sel_vec) begin
      arr_req   = 1'b1;
      arr_we    = vec_we;
      arr_index = vec_index;
      arr_word  = vec_word;
      arr_way   = vec_way;
      arr_be    = vec_be;
      arr_wdata = vec_wdata;
      own_in    = vec_we ? OWN_NONE : OWN_VEC;
    end
  end

  assign sc_gnt  = sel_sc;
  assign vec_gnt = sel_vec;

  // age: counts consecutive vector denials, refill denials included
  always_ff @(posedge clk_i) begin
    if (rst_i)                             age <= '0;
    else if (sel_vec)                      age <= '0;
    else if (vec_req && (age != AGE_MAX))  age <= age + 1'b1;
  end

  // owner pipe p0..p(RD_LAT-1): flushed on reset, lane rides unreset
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < RD_LAT; i++) own_p[i] <= OWN_NONE;
    end else begin
      own_p[0] <= own_in;
      for (int i = 1; i < RD_LAT; i++) own_p[i] <= own_p[i-1];
    end
  end

  always_ff @(posedge clk_i) begin
    lane_p[0] <= vec_lane;
    for (int i = 1; i < RD_LAT; i++) lane_p[i] <= lane_p[i-1];
  end

  // response select at pipe exit
  assign own_out    = own_p[RD_LAT-1];
  assign sc_rvalid  = !rst_i && (own_out == OWN_SC);
  assign vec_rvalid = !rst_i && (own_out == OWN_VEC);
  assign sc_rdata   = sc_rvalid  ? arr_rdata : '0;
  assign vec_rdata  = vec_rvalid ? arr_rdata : '0;
  assign vec_rlane  = vec_rvalid ? lane_p[RD_LAT-1] : '0;

endmodule

// File: rtl/rv64g_l1_bank_arbiter.sv
// L1 data-array bank arbiter: refill broadcast, scalar demux, per-bank slices.
// Optional performance counters are built when L1_ARB_PERF_EN is defined.
module rv64g_l1_bank_arbiter
  import rv64g_l1_pkg::*;
#(
  parameter int NUM_BANKS    = 8,
  parameter int INDEX_W      = 5,
  parameter int RD_LAT       = 1,
  parameter int STARVE_LIMIT = 3
) (
  input logic                     clk_i,
  input logic                     rst_i,
  rv64g_l1_bank_arbiter_if.slave  bus
);
  logic [NUM_BANKS-1:0] sc_gnt_b;
  logic [NUM_BANKS-1:0] sc_rvalid_b;
  logic [63:0]          sc_rdata_b [NUM_BANKS];
  logic [63:0]          sc_rdata;

  assign bus.refill_gnt_o = bus.refill_req_i && !rst_i;

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    rv64g_l1_bank_arb_slice #(
      .INDEX_W      (INDEX_W),
      .RD_LAT       (RD_LAT),
      .STARVE_LIMIT (STARVE_LIMIT),
      .BANK_ID      (3'(b))
    ) u_slice (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .refill_req   (bus.refill_req_i),
      .refill_index (bus.refill_index_i),
      .refill_way   (bus.refill_way_i),
      .refill_wdata (bus.refill_data_i[b*64 +: 64]),
      .sc_req       (bus.sc_req_i && (bus.sc_word_i == 3'(b))),
      .sc_we        (bus.sc_we_i),
      .sc_index     (bus.sc_index_i),
      .sc_word      (bus.sc_word_i),
      .sc_way       (bus.sc_way_i),
      .sc_be        (bus.sc_be_i),
      .sc_wdata     (bus.sc_wdata_i),
      .vec_req      (bus.vec_req_i[b]),
      .vec_we       (bus.vec_we_i[b]),
      .vec_index    (bus.vec_index_i[b*INDEX_W +: INDEX_W]),
      .vec_word     (bus.vec_word_i[b*3 +: 3]),
      .vec_way      (bus.vec_way_i[b*3 +: 3]),
      .vec_be       (bus.vec_be_i[b*8 +: 8]),
      .vec_wdata    (bus.vec_wdata_i[b*64 +: 64]),
      .vec_lane     (bus.vec_src_lane_i[b*3 +: 3]),
      .arr_rdata    (bus.arr_rdata_i[b*64 +: 64]),
      .sc_gnt       (sc_gnt_b[b]),
      .vec_gnt      (bus.vec_gnt_o[b]),
      .arr_req      (bus.arr_req_o[b]),
      .arr_we       (bus.arr_we_o[b]),
      .arr_index    (bus.arr_index_o[b*INDEX_W +: INDEX_W]),
      .arr_word     (bus.arr_word_o[b*3 +: 3]),
      .arr_way      (bus.arr_way_o[b*3 +: 3]),
      .arr_be       (bus.arr_be_o[b*8 +: 8]),
      .arr_wdata    (bus.arr_wdata_o[b*64 +: 64]),
      .sc_rvalid    (sc_rvalid_b[b]),
      .sc_rdata     (sc_rdata_b[b]),
      .vec_rvalid   (bus.vec_rvalid_o[b]),
      .vec_rdata    (bus.vec_rdata_o[b*64 +: 64]),
      .vec_rlane    (bus.vec_rlane_o[b*3 +: 3])
    );
  end

  // Only one scalar read can be in flight, so OR-combining is collision free.
  always_comb begin
    sc_rdata = '0;
    for (int b = 0; b < NUM_BANKS; b++) sc_rdata = sc_rdata | sc_rdata_b[b];
  end

  assign bus.sc_gnt_o    = |sc_gnt_b;
  assign bus.sc_rvalid_o = |sc_rvalid_b;
  assign bus.sc_rdata_o  = sc_rdata;

`ifdef L1_ARB_PERF_EN
  logic [31:0] conflict_cnt;
  logic [31:0] refstall_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      conflict_cnt <= '0;
      refstall_cnt <= '0;
    end else begin
      if (bus.sc_req_i && bus.vec_req_i[bus.sc_word_i] && !bus.refill_req_i)
        conflict_cnt <= conflict_cnt + 32'd1;
      if (bus.refill_gnt_o && (bus.sc_req_i || (|bus.vec_req_i)))
        refstall_cnt <= refstall_cnt + 32'd1;
    end
  end

  assign bus.perf_conflict_o = conflict_cnt;
  assign bus.perf_refstall_o = refstall_cnt;
`else
  assign bus.perf_conflict_o = '0;
  assign bus.perf_refstall_o = '0;
`endif

endmodule

// File: tb/tb_rv64g_l1_bank_arbiter.sv
// Directed bench for rv64g_l1_bank_arbiter with a read-return scoreboard.
module tb_rv64g_l1_bank_arbiter;
  localparam int NB = 8;
  localparam int IW = 5;

  logic clk;
  logic rst;
  int   cyc;
  int   n_cmp;
  int   n_err;

  typedef struct {
    bit          is_vec;
    int          bank;
    logic [2:0]  lane;
    int          due;
  } exp_t;

  exp_t exp_q[$];

  rv64g_l1_bank_arbiter_if #(.NUM_BANKS(NB), .INDEX_W(IW)) bus ();

  rv64g_l1_bank_arbiter #(
    .NUM_BANKS(NB), .INDEX_W(IW), .RD_LAT(1), .STARVE_LIMIT(3)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [63:0] mkdata(input int b, input int c);
    return {16'hBEEF, 8'(b), 8'h5A, 32'(c)};
  endfunction

  // bank model: data changes every cycle so a mistimed return is visible
  always_comb begin
    bus.arr_rdata_i = '0;
    for (int b = 0; b < NB; b++) bus.arr_rdata_i[b*64 +: 64] = mkdata(b, cyc);
  end

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // response monitor: sc first, then vector banks ascending
  always @(negedge clk) begin
    exp_t e;
    if (bus.sc_rvalid_o) begin
      if (exp_q.size() == 0) check_eq("sc_rvalid_unexpected", 1, 0);
      else begin
        e = exp_q.pop_front();
        check_eq("sc_ret_kind", 64'(e.is_vec), 0);
        check_eq("sc_rdata", bus.sc_rdata_o, mkdata(e.bank, e.due));
      end
    end
    for (int b = 0; b < NB; b++) begin
      if (bus.vec_rvalid_o[b]) begin
        if (exp_q.size() == 0) check_eq("vec_rvalid_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          check_eq("vec_ret_kind", 64'(e.is_vec), 1);
          check_eq("vec_ret_bank", 64'(b), 64'(e.bank));
          check_eq("vec_rlane", bus.vec_rlane_o[b*3 +: 3], e.lane);
          check_eq("vec_rdata", bus.vec_rdata_o[b*64 +: 64], mkdata(e.bank, e.due));
        end
      end
    end
    while (exp_q.size() != 0 && exp_q[0].due <= cyc) begin
      e = exp_q.pop_front();
      check_eq("ret_missing", 0, 1);
    end
  end

  task automatic push_ret(input bit is_vec, input int bank, input logic [2:0] lane);
    exp_q.push_back('{is_vec: is_vec, bank: bank, lane: lane, due: cyc + 1});
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.refill_req_i = 1'b0;
    bus.sc_req_i     = 1'b0;
    bus.sc_we_i      = 1'b0;
    bus.vec_req_i    = '0;
    bus.vec_we_i     = '0;
  endtask

  task automatic sc_drive(input logic we, input logic [2:0] word, input logic [63:0] wdata,
                          input logic [7:0] be);
    bus.sc_req_i   = 1'b1;
    bus.sc_we_i    = we;
    bus.sc_word_i  = word;
    bus.sc_index_i = 5'h0A;
    bus.sc_way_i   = 3'd2;
    bus.sc_be_i    = be;
    bus.sc_wdata_i = wdata;
  endtask

  // scalar and vector reads held on one bank; vector wins on the 4th cycle
  task automatic run_starve(input int bank);
    logic [2:0] ln;
    ln = bus.vec_src_lane_i[bank*3 +: 3];
    for (int c = 0; c < 5; c++) begin
      sc_drive(1'b0, 3'(bank), '0, 8'hFF);
      bus.vec_req_i = NB'(1) << bank;
      if (c == 3) push_ret(1'b1, bank, ln);
      else        push_ret(1'b0, bank, 3'd0);
      @(negedge clk);
      check_eq($sformatf("starve_sc_gnt_c%0d", c), bus.sc_gnt_o, (c == 3) ? 0 : 1);
      check_eq($sformatf("starve_vec_gnt_c%0d", c), bus.vec_gnt_o[bank], (c == 3) ? 1 : 0);
      next_cycle();
    end
    idle();
    next_cycle();
  endtask

  initial begin
    logic [63:0] sc_wd;
    logic [7:0]  exp_gnt;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    rst   = 1'b1;
    idle();
    bus.refill_index_i = 5'h07;
    bus.refill_way_i   = 3'd5;
    for (int b = 0; b < NB; b++) begin
      bus.refill_data_i[b*64 +: 64]     = {32'hF111_0000 | 32'(b), 32'h0000_ABCD};
      bus.vec_index_i[b*IW +: IW]       = IW'(b + 1);
      bus.vec_word_i[b*3 +: 3]          = 3'(b);
      bus.vec_way_i[b*3 +: 3]           = 3'(7 - b);
      bus.vec_be_i[b*8 +: 8]            = 8'hFF;
      bus.vec_wdata_i[b*64 +: 64]       = {32'h7EC0_0000 | 32'(b), 32'h1234_5678};
      bus.vec_src_lane_i[b*3 +: 3]      = 3'(b) ^ 3'd3;
    end
    sc_drive(1'b0, 3'd4, '0, 8'hFF);
    bus.vec_req_i = '1;

    // reset with requests present: everything must stay quiet
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("rst_sc_gnt", bus.sc_gnt_o, 0);
    check_eq("rst_vec_gnt", bus.vec_gnt_o, 0);
    check_eq("rst_arr_req", bus.arr_req_o, 0);
    check_eq("rst_arr_we", bus.arr_we_o, 0);
    check_eq("rst_arr_index", bus.arr_index_o, 0);
    check_eq("rst_sc_rvalid", bus.sc_rvalid_o, 0);
    check_eq("rst_vec_rvalid", bus.vec_rvalid_o, 0);
    check_eq("rst_perf_conflict", bus.perf_conflict_o, 0);
    check_eq("rst_perf_refstall", bus.perf_refstall_o, 0);
    next_cycle();
    rst = 1'b0;
    idle();
    next_cycle();

    // 1: scalar read on bank 3
    sc_drive(1'b0, 3'd3, '0, 8'hFF);
    push_ret(1'b0, 3, 3'd0);
    @(negedge clk);
    check_eq("t1_sc_gnt", bus.sc_gnt_o, 1);
    check_eq("t1_arr_req", bus.arr_req_o, 8'h08);
    check_eq("t1_arr_we", bus.arr_we_o, 8'h00);
    check_eq("t1_arr_index3", bus.arr_index_o[3*IW +: IW], 5'h0A);
    check_eq("t1_arr_way3", bus.arr_way_o[3*3 +: 3], 3'd2);
    check_eq("t1_arr_word3", bus.arr_word_o[3*3 +: 3], 3'd3);
    check_eq("t1_idle_index0", bus.arr_index_o[0 +: IW], 0);
    next_cycle();
    idle();
    @(negedge clk);
    check_eq("t1_sc_rvalid", bus.sc_rvalid_o, 1);
    next_cycle();

    // 2: all-bank vector reads plus scalar write on bank 2
    sc_wd = 64'h1122_3344_5566_7788;
    sc_drive(1'b1, 3'd2, sc_wd, 8'h0F);
    bus.vec_req_i = '1;
    for (int b = 0; b < NB; b++)
      if (b != 2) push_ret(1'b1, b, 3'(b) ^ 3'd3);
    @(negedge clk);
    check_eq("t2_vec_gnt", bus.vec_gnt_o, 8'hFB);
    check_eq("t2_sc_gnt", bus.sc_gnt_o, 1);
    check_eq("t2_arr_req", bus.arr_req_o, 8'hFF);
    check_eq("t2_arr_we", bus.arr_we_o, 8'h04);
    check_eq("t2_arr_wdata2", bus.arr_wdata_o[2*64 +: 64], sc_wd);
    check_eq("t2_arr_be2", bus.arr_be_o[2*8 +: 8], 8'h0F);
    check_eq("t2_arr_index5", bus.arr_index_o[5*IW +: IW], 5'd6);
    next_cycle();
    idle();
    bus.vec_req_i = 8'h04;
    push_ret(1'b1, 2, 3'd2 ^ 3'd3);
    @(negedge clk);
    check_eq("t2_vec_gnt_retry", bus.vec_gnt_o, 8'h04);
    next_cycle();
    idle();
    next_cycle();

    // 3: starvation override on bank 5
    run_starve(5);

    // 4: refill beats everything
    bus.refill_req_i = 1'b1;
    sc_drive(1'b0, 3'd1, '0, 8'hFF);
    bus.vec_req_i = '1;
    @(negedge clk);
    check_eq("t4_refill_gnt", bus.refill_gnt_o, 1);
    check_eq("t4_arr_req", bus.arr_req_o, 8'hFF);
    check_eq("t4_arr_we", bus.arr_we_o, 8'hFF);
    check_eq("t4_arr_be", bus.arr_be_o, 64'hFFFF_FFFF_FFFF_FFFF);
    check_eq("t4_sc_gnt", bus.sc_gnt_o, 0);
    check_eq("t4_vec_gnt", bus.vec_gnt_o, 0);
    check_eq("t4_arr_wdata6", bus.arr_wdata_o[6*64 +: 64], {32'hF111_0006, 32'h0000_ABCD});
    check_eq("t4_arr_word7", bus.arr_word_o[7*3 +: 3], 3'd7);
    check_eq("t4_arr_index0", bus.arr_index_o[0 +: IW], 5'h07);
    next_cycle();
    idle();
    @(negedge clk);
    check_eq("t4_no_sc_rvalid", bus.sc_rvalid_o, 0);
    check_eq("t4_no_vec_rvalid", bus.vec_rvalid_o, 0);
    next_cycle();

    // 5: vector read on bank 6 from lane 1, then reset mid-read
    bus.vec_src_lane_i[6*3 +: 3] = 3'd1;
    bus.vec_req_i = 8'h40;
    @(negedge clk);
    check_eq("t5_vec_gnt", bus.vec_gnt_o, 8'h40);
    next_cycle();
    rst = 1'b1;
    sc_drive(1'b0, 3'd0, '0, 8'hFF);
    @(negedge clk);
    check_eq("t5_vec_rvalid", bus.vec_rvalid_o, 0);
    check_eq("t5_vec_rdata", bus.vec_rdata_o[6*64 +: 64], 0);
    check_eq("t5_vec_rlane", bus.vec_rlane_o, 0);
    check_eq("t5_vec_gnt_rst", bus.vec_gnt_o, 0);
    check_eq("t5_sc_gnt_rst", bus.sc_gnt_o, 0);
    check_eq("t5_arr_req_rst", bus.arr_req_o, 0);
    check_eq("t5_arr_wdata_rst", bus.arr_wdata_o[0 +: 64], 0);
    next_cycle();
    rst = 1'b0;
    idle();
    next_cycle();
    @(negedge clk);
    check_eq("t5_after_rvalid", bus.vec_rvalid_o, 0);
    next_cycle();
    run_starve(5);

    // 6: perf counters after a fresh reset
    rst = 1'b1;
    next_cycle();
    rst = 1'b0;
    for (int c = 0; c < 4; c++) begin
      sc_drive(1'b1, 3'd0, 64'(c), 8'hFF);
      bus.vec_req_i = 8'h01;
      bus.vec_we_i  = 8'h01;
      exp_gnt = (c == 3) ? 8'h01 : 8'h00;
      @(negedge clk);
      check_eq($sformatf("t6_vec_gnt_c%0d", c), bus.vec_gnt_o, exp_gnt);
      next_cycle();
    end
    idle();
    for (int c = 0; c < 2; c++) begin
      bus.refill_req_i = 1'b1;
      sc_drive(1'b1, 3'd4, '0, 8'hFF);
      next_cycle();
    end
    idle();
    next_cycle();
    @(negedge clk);
`ifdef L1_ARB_PERF_EN
    check_eq("t6_perf_conflict", bus.perf_conflict_o, 4);
    check_eq("t6_perf_refstall", bus.perf_refstall_o, 2);
`else
    check_eq("t6_perf_conflict", bus.perf_conflict_o, 0);
    check_eq("t6_perf_refstall", bus.perf_refstall_o, 0);
`endif
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("scoreboard_drained", 64'(exp_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
